add8u_err_eval: RTL and testbench
=================================

# add8u_err_eval

Exhaustive on-chip error evaluator for 8-bit unsigned approximate adders in the add8u family. It sweeps all 65536 operand pairs into an attached adder (DUT) and compares each 9-bit result against the exact sum. It accumulates sum of absolute error, worst-case error with its first operands, and error count. It sits directly around the adder, feeding its A/B inputs and consuming its O output, and is used for FPGA-side characterisation of the MAE/WCE/EP figures.

## Interface
- DUT_LATENCY, default 0: register stages inside the attached adder (0 = purely combinational); range 0..4.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- dut_a  out  8  operand A driven to the adder.
- dut_b  out  8  operand B driven to the adder.
- dut_o  in  9  adder result O.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; statistics valid.
- sum_abs_err  out  25  Σ|O − (A+B)| over all pairs (max 33 488 896 fits).
- wce  out  9  maximum |O − (A+B)|.
- wce_a, wce_b  out  8 each  operands of the first pair reaching wce.
- err_cnt  out  17  number of pairs with O ≠ A+B (max 65536).

## Operation
- FSM states:
  - IDLE: start → RUN; clears all statistics and counter.
  - RUN: issues one pair per cycle; after issuing the pair with cnt = 65535 → DRAIN.
  - DRAIN: no new issues; waits for the valid pipeline to empty → DONE.
  - DONE: holds results; start → RUN, clearing the statistics first.
- Operand generation: 16-bit counter cnt; dut_a = cnt[7:0], dut_b = cnt[15:8]; cnt wraps to 0 on entering DRAIN.
- Alignment: a DUT_LATENCY-deep shift register carries valid, a and b alongside the DUT.
- S1 registers dut_o, exact = a + b (9-bit, no truncation), a, b and valid.
- S2 registers err = |o − exact| as 9 bits, computed as a 10-bit signed difference before taking the magnitude; a, b and valid travel with it.
- S3 (accumulate, valid only):
  - sum_abs_err += err.
  - err_cnt += (err ≠ 0).
  - If err > wce: update wce, wce_a and wce_b. Strict comparison keeps the first occurrence in sweep order.
- start in RUN or DRAIN is ignored. rst in any state returns to IDLE and clears everything, including pipeline valids.
- dut_a/dut_b hold their last value (0 after the wrap) when not in RUN; the DUT output is ignored unless the valid bit travelling with it is set.

## Timing
- Reset values: every output is 0, busy = 0, done = 0, state = IDLE.
- Sampling start at edge E0:
  - busy = 1 and pair k is on dut_a/dut_b during cycle k+1 (k = 0..65535).
  - The DUT result for pair k is sampled at the end of cycle k+1+DUT_LATENCY.
  - The statistics include pair k from cycle k+4+DUT_LATENCY.
- done rises, and busy falls, in cycle 65539+DUT_LATENCY, the same cycle the final statistics are visible. Total sweep cost is 65539+DUT_LATENCY cycles.
- Restarting from DONE: done drops and busy rises in the cycle after start is sampled; the statistics read 0 in that cycle.
- No back-pressure: the DUT must accept one pair per cycle.

## Structure
- Package add8u_eval_pkg holds:
  - N_PAIRS = 65536 and the output widths (SUM_W = 25, CNT_W = 17, ERR_W = 9).
  - The FSM state enum {IDLE, RUN, DRAIN, DONE}.
- One natural sub-module: add8u_err_acc, covering S2 and S3 (abs difference, sum, count, worst-case tracking), with a clear input and valid qualifier.
- The top module holds the FSM, counter and alignment delay line.
- The bench instantiates the adder under evaluation externally; it is not instantiated inside this block.

## Test plan
- Exact adder (O = A+B), DUT_LATENCY = 0 → sum_abs_err = 0, wce = 0, wce_a = wce_b = 0, err_cnt = 0; done in cycle 65539.
- O = {(A+B)[8:1], A[0]} → sum_abs_err = 32768, wce = 1, err_cnt = 32768, wce_a = 0, wce_b = 1.
- O = 0 constant, DUT_LATENCY = 2 → sum_abs_err = 16 711 680, wce = 510, wce_a = wce_b = 255, err_cnt = 65535; done in cycle 65541.
- Any DUT: start pulsed repeatedly during RUN → no restart, identical results, done at the same cycle as an unperturbed run.
- Reset asserted asynchronously mid-RUN (cnt ≈ 1000) → all outputs 0 immediately. A subsequent start gives results identical to a clean run.
- Back-to-back sweeps: start in DONE with the exact adder after an O = 0 run → statistics clear to 0 at restart and finish at 0.

Source files
------------

// File: rtl/add8u_eval_pkg.sv
// Shared widths, FSM encoding and pipeline tag for the add8u error evaluator.
package add8u_eval_pkg;

    localparam int N_PAIRS = 65536;
    localparam int SUM_W   = 25;
    localparam int CNT_W   = 17;
    localparam int ERR_W   = 9;
    localparam int OP_W    = $clog2(N_PAIRS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Operands plus their exact sum, carried alongside the adder under test.
    typedef struct packed {
        logic [8:0] exact;
        logic [7:0] b;
        logic [7:0] a;
    } tag_t;

endpackage

// File: rtl/add8u_err_acc.sv
// Error magnitude stage and running statistics (sum, count, first worst case).
module add8u_err_acc
    import add8u_eval_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             vld,
    input  logic [8:0]       o,
    input  logic [8:0]       exact,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [ERR_W-1:0] wce,
    output logic [7:0]       wce_a,
    output logic [7:0]       wce_b,
    output logic [CNT_W-1:0] err_cnt
);

    logic signed [9:0] diff;
    logic [ERR_W-1:0]  err_nxt;
    logic [ERR_W-1:0]  s2_err;
    logic              s2_vld;
    logic [7:0]        s2_a, s2_b;

    // 10-bit signed difference so both O < exact and O > exact are covered.
    assign diff    = $signed({1'b0, o}) - $signed({1'b0, exact});
    assign err_nxt = ERR_W'(diff[9] ? -diff : diff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_err <= '0;
            s2_a   <= '0;
            s2_b   <= '0;
        end else begin
            s2_vld <= vld && !clear;
            s2_err <= err_nxt;
            s2_a   <= a;
            s2_b   <= b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_abs_err <= '0;
            err_cnt     <= '0;
            wce         <= '0;
            wce_a       <= '0;
            wce_b       <= '0;
        end else if (clear) begin
            sum_abs_err <= '0;
            err_cnt     <= '0;
            wce         <= '0;
            wce_a       <= '0;
            wce_b       <= '0;
        end else if (s2_vld) begin
            sum_abs_err <= sum_abs_err + SUM_W'(s2_err);
            err_cnt     <= err_cnt + CNT_W'(s2_err != '0);
            // Strict compare keeps the earliest pair in sweep order.
            if (s2_err > wce) begin
                wce   <= s2_err;
                wce_a <= s2_a;
                wce_b <= s2_b;
            end
        end
    end

endmodule

// File: rtl/add8u_err_eval.sv
// Exhaustive sweep of all 8x8-bit operand pairs through an external adder,
// collecting MAE/WCE/EP statistics against the exact sum.
module add8u_err_eval
    import add8u_eval_pkg::*;
#(
    parameter int DUT_LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [7:0]       dut_a,
    output logic [7:0]       dut_b,
    input  logic [8:0]       dut_o,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [ERR_W-1:0] wce,
    output logic [7:0]       wce_a,
    output logic [7:0]       wce_b,
    output logic [CNT_W-1:0] err_cnt
);

    state_t              state, state_nxt;
    logic [OP_W-1:0]     cnt;
    logic                acc_clr;
    tag_t                issue;
    logic [DUT_LATENCY:0] vld_pipe;
    tag_t [DUT_LATENCY:0] tag_pipe;
    logic [8:0]          s1_o;

    assign dut_a       = cnt[7:0];
    assign dut_b       = cnt[15:8];
    assign issue.a     = cnt[7:0];
    assign issue.b     = cnt[15:8];
    assign issue.exact = {1'b0, cnt[7:0]} + {1'b0, cnt[15:8]};
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        unique case (state)
            IDLE, DONE: if (start) begin
                state_nxt = RUN;
                acc_clr   = 1'b1;
            end
            RUN:   if (cnt == OP_W'(N_PAIRS - 1)) state_nxt = DRAIN;
            // The last result may still sit in the abs-diff stage; it lands
            // on the same edge that enters DONE.
            DRAIN: if (vld_pipe == '0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               cnt <= '0;
        else if (acc_clr)      cnt <= '0;
        else if (state == RUN) cnt <= cnt + 1'b1;
    end

    // Stages 0..DUT_LATENCY-1 mirror the adder's registers; the last stage,
    // captured together with dut_o, is the S1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            s1_o     <= '0;
        end else begin
            vld_pipe[0] <= (state == RUN);
            tag_pipe[0] <= issue;
            for (int i = 1; i <= DUT_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
            s1_o <= dut_o;
        end
    end

    add8u_err_acc u_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (acc_clr),
        .vld         (vld_pipe[DUT_LATENCY]),
        .o           (s1_o),
        .exact       (tag_pipe[DUT_LATENCY].exact),
        .a           (tag_pipe[DUT_LATENCY].a),
        .b           (tag_pipe[DUT_LATENCY].b),
        .sum_abs_err (sum_abs_err),
        .wce         (wce),
        .wce_a       (wce_a),
        .wce_b       (wce_b),
        .err_cnt     (err_cnt)
    );

endmodule

// File: tb/tb_add8u_err_eval.sv
// Five evaluators in parallel, each around a behavioural approximate adder.
module tb_add8u_err_eval;
    import add8u_eval_pkg::*;

    localparam int NI = 5;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   loa_k = 3;

    logic        rst   [NI];
    logic        start [NI];
    logic [7:0]  da    [NI];
    logic [7:0]  db    [NI];
    logic [8:0]  dout  [NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic [24:0] sae   [NI];
    logic [8:0]  wce   [NI];
    logic [7:0]  wa    [NI];
    logic [7:0]  wb    [NI];
    logic [16:0] ec    [NI];
    int          mode  [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural adders: 0 exact, 1 LSB-from-A, 2 constant zero, 3 lower-part OR.
    function automatic int adder_fn(input int md, input int a, input int b);
        int s = a + b;
        int m = (1 << loa_k) - 1;
        case (md)
            1:       return (s & 'h1FE) | (a & 1);
            2:       return 0;
            3:       return (s & ~m) | ((a | b) & m);
            default: return s;
        endcase
    endfunction

    for (genvar i = 0; i < NI; i++) begin : g_inst
        localparam int L = (i == 2) ? 2 : 0;
        add8u_err_eval #(.DUT_LATENCY(L)) u_dut (
            .clk(clk), .rst(rst[i]), .start(start[i]),
            .dut_a(da[i]), .dut_b(db[i]), .dut_o(dout[i]),
            .busy(busy[i]), .done(done[i]), .sum_abs_err(sae[i]),
            .wce(wce[i]), .wce_a(wa[i]), .wce_b(wb[i]), .err_cnt(ec[i])
        );
        if (L == 0) begin : g_comb
            assign dout[i] = 9'(adder_fn(mode[i], int'(da[i]), int'(db[i])));
        end else begin : g_reg
            logic [8:0] p1 = '0;
            logic [8:0] p2 = '0;
            always @(posedge clk) begin
                p1 <= 9'(adder_fn(mode[i], int'(da[i]), int'(db[i])));
                p2 <= p1;
            end
            assign dout[i] = p2;
        end
    end

    // Statistics over the first m pairs of the sweep (a = k % 256, b = k / 256).
    task automatic model(input int md, input int m, output longint s,
                         output int w, output int wa_, output int wb_, output int c);
        s = 0; w = 0; wa_ = 0; wb_ = 0; c = 0;
        for (int k = 0; k < m; k++) begin
            int a = k % 256;
            int b = k / 256;
            int e = adder_fn(md, a, b) - (a + b);
            if (e < 0) e = -e;
            s += e;
            if (e != 0) c++;
            if (e > w) begin w = e; wa_ = a; wb_ = b; end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input longint exp);
        checks++;
        assert (obs === 64'(exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input int i, input string tag, input longint s,
                             input int w, input int a, input int b, input int c);
        chk($sformatf("%s%0d_sum", tag, i), 64'(sae[i]), s);
        chk($sformatf("%s%0d_wce", tag, i), 64'(wce[i]), w);
        chk($sformatf("%s%0d_wce_a", tag, i), 64'(wa[i]), a);
        chk($sformatf("%s%0d_wce_b", tag, i), 64'(wb[i]), b);
        chk($sformatf("%s%0d_cnt", tag, i), 64'(ec[i]), c);
    endtask

    initial begin
        longint xs [NI];
        int     xw [NI], xa [NI], xb [NI], xc [NI], xdone [NI];
        bit     seen [NI];
        int     s1 [NI];
        longint ms;
        int     mw, ma, mb, mc;
        int     rst_pt, mid_b, mid_e, c_rs;
        bit     c_go;

        loa_k  = $urandom_range(2, 5);
        mode   = '{0, 1, 2, 1, 3};
        xdone  = '{65539, 65539, 65541, 65539, 65539};
        rst_pt = $urandom_range(990, 1010);
        mid_b  = $urandom_range(4, 60000);
        mid_e  = $urandom_range(4, 60000);
        c_go   = 1'b0;
        c_rs   = 0;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; seen[i] = 1'b0; s1[i] = 0;
        end

        model(0, N_PAIRS, xs[0], xw[0], xa[0], xb[0], xc[0]);
        xs[1] = 32768;    xw[1] = 1;   xa[1] = 0;   xb[1] = 1;   xc[1] = 32768;
        xs[2] = 16711680; xw[2] = 510; xa[2] = 255; xb[2] = 255; xc[2] = 65535;
        model(1, N_PAIRS, xs[3], xw[3], xa[3], xb[3], xc[3]);
        model(3, N_PAIRS, xs[4], xw[4], xa[4], xb[4], xc[4]);

        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_busy%0d", i), 64'(busy[i]), 0);
            chk($sformatf("rst_done%0d", i), 64'(done[i]), 0);
            chk($sformatf("rst_dut_a%0d", i), 64'(da[i]), 0);
            chk_stats(i, "rst", 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) start[i] = 1'b1;

        for (int n = 1; n <= 67000 && !seen[3]; n++) begin
            @(negedge clk);
            if (n == 1) begin
                for (int i = 0; i < NI; i++) begin start[i] = 1'b0; s1[i] = cyc; end
                chk("run_busy0", 64'(busy[0]), 1);
                chk("run_pair0_b", 64'(db[0]), 0);
            end
            // Instance 0: stray starts during RUN and one in DRAIN.
            start[0] = ((n >= 2 && n <= 65000 && $urandom_range(0, 99) < 3) || n == 65537);

            if (n == mid_b) begin
                model(1, n - 3, ms, mw, ma, mb, mc);
                chk_stats(1, "mid", ms, mw, ma, mb, mc);
            end
            if (n == mid_e) begin
                model(3, n - 3, ms, mw, ma, mb, mc);
                chk_stats(4, "mid", ms, mw, ma, mb, mc);
            end

            // Instance 3: asynchronous reset mid-run, then a clean sweep.
            if (n == rst_pt) begin
                model(1, n - 3, ms, mw, ma, mb, mc);
                chk_stats(3, "pre_rst", ms, mw, ma, mb, mc);
                chk("pre_rst_dut_a", 64'(da[3]), (n - 1) % 256);
                #1 rst[3] = 1'b1;
                #1;
                chk("arst_busy", 64'(busy[3]), 0);
                chk("arst_done", 64'(done[3]), 0);
                chk("arst_dut_a", 64'(da[3]), 0);
                chk("arst_dut_b", 64'(db[3]), 0);
                chk_stats(3, "arst", 0, 0, 0, 0, 0);
            end
            if (n == rst_pt + 1) rst[3] = 1'b0;
            if (n == rst_pt + 3) start[3] = 1'b1;
            if (n == rst_pt + 4) begin
                start[3] = 1'b0;
                s1[3] = cyc;
                chk("rerun_busy", 64'(busy[3]), 1);
                chk("rerun_dut_a", 64'(da[3]), 0);
            end

            for (int i = 0; i < NI; i++) begin
                if (!seen[i] && done[i] === 1'b1) begin
                    seen[i] = 1'b1;
                    chk($sformatf("done_cycle%0d", i), 64'(cyc - s1[i] + 1), xdone[i]);
                    chk($sformatf("done_busy%0d", i), 64'(busy[i]), 0);
                    chk_stats(i, "final", xs[i], xw[i], xa[i], xb[i], xc[i]);
                end
            end

            // Instance 2: back-to-back sweep with the exact adder.
            if (seen[2] && !c_go) begin
                c_go = 1'b1;
                c_rs = n;
                mode[2] = 0;
                start[2] = 1'b1;
            end else if (c_go && n == c_rs + 1) begin
                start[2] = 1'b0;
                s1[2] = cyc;
                chk("b2b_busy", 64'(busy[2]), 1);
                chk("b2b_done", 64'(done[2]), 0);
                chk_stats(2, "b2b_clr", 0, 0, 0, 0, 0);
            end else if (c_go && n == c_rs + 500) begin
                chk("b2b_mid_busy", 64'(busy[2]), 1);
                chk_stats(2, "b2b_mid", 0, 0, 0, 0, 0);
            end
        end

        for (int i = 0; i < NI; i++)
            chk($sformatf("done_seen%0d", i), 64'(seen[i]), 1);
        chk("b2b_started", 64'(c_go), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
